// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into instruction bits [31:7] for the I/S/B/J formats.
// Two-stage valid/ready pipeline with range/alignment flags and output handshake counters.
`timescale 1ns/1ps
module imm_encoder #(
   parameter int CNT_W = 16,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inValid,
   output logic             inReady,
   input  logic [31:0]      immValue,
   input  logic [1:0]       immSrc,
   output logic             outValid,
   input  logic             outReady,
   output logic [24:0]      inm,
   output logic             rangeErr,
   output logic             alignErr,
   output logic [CNT_W-1:0] encCount,
   output logic [ERR_W-1:0] errCount
);
   typedef enum logic [1:0] {FMT_I = 2'b00, FMT_S = 2'b01, FMT_B = 2'b10, FMT_J = 2'b11} fmt_e;

   logic             r_s1_valid;
   logic [20:0]      r_s1_imm;
   logic [1:0]       r_s1_src;
   logic             r_s1_range;
   logic             r_s1_align;
   logic             r_s2_valid;
   logic [24:0]      r_inm;
   logic             r_range;
   logic             r_align;
   logic [CNT_W-1:0] r_enc_cnt;
   logic [ERR_W-1:0] r_err_cnt;

   logic             w_s2_load;
   logic             w_s1_load;
   logic             w_out_hs;
   logic             w_fit11;
   logic             w_fit12;
   logic             w_fit20;
   logic             w_range;
   logic             w_align;
   logic [24:0]      w_packed;

   assign w_out_hs  = r_s2_valid & outReady;
   assign w_s2_load = ~r_s2_valid | outReady;
   assign w_s1_load = ~r_s1_valid | w_s2_load;
   assign inReady   = w_s1_load;

   // A value fits when every bit above the format's sign position equals the sign bit.
   assign w_fit11 = (&immValue[31:11]) | ~(|immValue[31:11]);
   assign w_fit12 = (&immValue[31:12]) | ~(|immValue[31:12]);
   assign w_fit20 = (&immValue[31:20]) | ~(|immValue[31:20]);

   always_comb begin
      w_range = 1'b0;
      w_align = 1'b0;
      case (immSrc)
         FMT_I, FMT_S: w_range = ~w_fit11;
         FMT_B: begin
            w_range = ~w_fit12;
            w_align = immValue[0];
         end
         default: begin
            w_range = ~w_fit20;
            w_align = immValue[0];
         end
      endcase
   end

   always_comb begin
      w_packed = '0;
      case (r_s1_src)
         FMT_I: w_packed[24:13] = r_s1_imm[11:0];
         FMT_S: begin
            w_packed[24:18] = r_s1_imm[11:5];
            w_packed[4:0]   = r_s1_imm[4:0];
         end
         FMT_B: begin
            w_packed[24]    = r_s1_imm[12];
            w_packed[23:18] = r_s1_imm[10:5];
            w_packed[4:1]   = r_s1_imm[4:1];
            w_packed[0]     = r_s1_imm[11];
         end
         default: begin
            w_packed[24]    = r_s1_imm[20];
            w_packed[23:14] = r_s1_imm[10:1];
            w_packed[13]    = r_s1_imm[11];
            w_packed[12:5]  = r_s1_imm[19:12];
         end
      endcase
      if (r_s1_range | r_s1_align) begin
         w_packed = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_valid <= 1'b0;
         r_s1_imm   <= '0;
         r_s1_src   <= '0;
         r_s1_range <= 1'b0;
         r_s1_align <= 1'b0;
         r_s2_valid <= 1'b0;
         r_inm      <= '0;
         r_range    <= 1'b0;
         r_align    <= 1'b0;
         r_enc_cnt  <= '0;
         r_err_cnt  <= '0;
      end else begin
         if (w_s1_load) begin
            r_s1_valid <= inValid;
            r_s1_imm   <= immValue[20:0];
            r_s1_src   <= immSrc;
            r_s1_range <= w_range;
            r_s1_align <= w_align;
         end
         // Output registers only move when the consumer has taken the current item or none is held.
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            r_inm      <= w_packed;
            r_range    <= r_s1_range;
            r_align    <= r_s1_align;
         end
         if (w_out_hs) begin
            r_enc_cnt <= r_enc_cnt + CNT_W'(1);
            if ((r_range | r_align) && (r_err_cnt != '1)) begin
               r_err_cnt <= r_err_cnt + ERR_W'(1);
            end
         end
      end
   end

   assign outValid = r_s2_valid;
   assign inm      = r_inm;
   assign rangeErr = r_range;
   assign alignErr = r_align;
   assign encCount = r_enc_cnt;
   assign errCount = r_err_cnt;
endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: driver pushes expected results into a queue, a monitor pops on each
// output handshake; legal items are also decoded back and compared with the original immediate.
`timescale 1ns/1ps
module tb_imm_encoder;
   logic        clk = 1'b0;
   logic        reset;
   logic        inValid;
   logic        inReady;
   logic [31:0] immValue;
   logic [1:0]  immSrc;
   logic        outValid;
   logic        outReady;
   logic [24:0] inm;
   logic        rangeErr;
   logic        alignErr;
   logic [15:0] encCount;
   logic [7:0]  errCount;

   imm_encoder #(.CNT_W(16), .ERR_W(8)) dut (
      .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
      .immValue(immValue), .immSrc(immSrc), .outValid(outValid), .outReady(outReady),
      .inm(inm), .rangeErr(rangeErr), .alignErr(alignErr),
      .encCount(encCount), .errCount(errCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [24:0] inm;
      logic        r;
      logic        a;
      logic [31:0] imm;
      logic [1:0]  src;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   rdy_mode = 1;   // 0: outReady low, 1: high, 2: random
   int   m_enc = 0;
   int   m_err = 0;

   // Reference: range from signed arithmetic, field placement from the format tables.
   function automatic exp_t model(input logic [31:0] imm, input logic [1:0] src);
      exp_t        e;
      longint      s;
      logic [24:0] p;
      s = longint'($signed(imm));
      p = '0;
      e.imm = imm;
      e.src = src;
      e.a = 1'b0;
      case (src)
         2'd0, 2'd1: e.r = (s < -2048) || (s > 2047);
         2'd2: begin
            e.r = (s < -4096) || (s > 4095);
            e.a = imm[0];
         end
         default: begin
            e.r = (s < -1048576) || (s > 1048575);
            e.a = imm[0];
         end
      endcase
      case (src)
         2'd0: p[24:13] = imm[11:0];
         2'd1: begin p[24:18] = imm[11:5]; p[4:0] = imm[4:0]; end
         2'd2: begin p[24] = imm[12]; p[23:18] = imm[10:5]; p[4:1] = imm[4:1]; p[0] = imm[11]; end
         default: begin p[24] = imm[20]; p[23:14] = imm[10:1]; p[13] = imm[11]; p[12:5] = imm[19:12]; end
      endcase
      e.inm = (e.r || e.a) ? 25'd0 : p;
      return e;
   endfunction

   // Sign-extending immediate decoder of the RISC-V formats.
   function automatic logic [31:0] decode(input logic [24:0] f, input logic [1:0] src);
      logic [31:0] i;
      i = {f, 7'b0};
      case (src)
         2'd0: return {{20{i[31]}}, i[31:20]};
         2'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
         2'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      endcase
   endfunction

   function automatic logic [31:0] rand_imm(input logic [1:0] src);
      if ($urandom_range(0, 9) == 0) return $urandom;
      case (src)
         2'd0, 2'd1: return 32'($urandom_range(0, 4095)) - 32'd2048;
         2'd2: return (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
         default: return (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_item(input exp_t e);
      int tries;
      bit ok;
      tries = 0;
      ok = 1'b0;
      @(negedge clk);
      inValid = 1'b1;
      immValue = e.imm;
      immSrc = e.src;
      while (!ok && tries < 200) begin
         #1;
         if (inReady) begin
            q.push_back(e);
            ok = 1'b1;
         end else begin
            @(negedge clk);
            tries++;
         end
      end
      if (!ok) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: imm=%h src=%0d never accepted", e.imm, e.src);
      end
      @(posedge clk);
      #1 inValid = 1'b0;
   endtask

   task automatic send_exp(input logic [31:0] imm, input logic [1:0] src,
                           input logic [24:0] x_inm, input logic x_r, input logic x_a);
      exp_t e;
      e.imm = imm; e.src = src; e.inm = x_inm; e.r = x_r; e.a = x_a;
      send_item(e);
   endtask

   task automatic send_model(input logic [31:0] imm, input logic [1:0] src);
      send_item(model(imm, src));
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (q.size() != 0 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      chk("drain_empty", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      inValid = 1'b0;
      q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0: outReady = 1'b0;
            1: outReady = 1'b1;
            default: outReady = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: counters every cycle, stability while stalled, scoreboard on each output handshake.
   initial begin
      exp_t        e;
      bit          hold;
      logic [24:0] h_inm;
      logic        h_r;
      logic        h_a;
      hold = 1'b0;
      h_inm = '0; h_r = 1'b0; h_a = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            m_enc = 0;
            m_err = 0;
            hold = 1'b0;
            continue;
         end
         chk("encCount", 32'(encCount), 32'(m_enc & 16'hFFFF));
         chk("errCount", 32'(errCount), 32'(m_err));
         if (hold) begin
            chk("stall_hold", {5'd0, outValid, rangeErr, alignErr, inm},
                {5'd0, 1'b1, h_r, h_a, h_inm});
         end
         if (outValid && outReady) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: inm=%h with empty scoreboard", inm);
            end else begin
               e = q.pop_front();
               chk("inm", 32'(inm), 32'(e.inm));
               chk("flags", {30'd0, rangeErr, alignErr}, {30'd0, e.r, e.a});
               if (!e.r && !e.a) chk("roundtrip", decode(inm, e.src), e.imm);
               m_enc++;
               if ((e.r || e.a) && m_err < 255) m_err++;
            end
         end
         hold = outValid && !outReady;
         h_inm = inm; h_r = rangeErr; h_a = alignErr;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int c;
      exp_t v4[4];
      reset = 1'b1;
      inValid = 1'b0;
      immValue = '0;
      immSrc = '0;
      outReady = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_outValid", 32'(outValid), 32'd0);
      chk("rst_inm", 32'(inm), 32'd0);
      chk("rst_flags", {30'd0, rangeErr, alignErr}, 32'd0);
      chk("rst_counts", {encCount, 8'd0, errCount}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 chk("rst_inReady", 32'(inReady), 32'd1);

      // Directed encodings with hand-computed results
      send_exp(32'hFFFF_FFFF, 2'd0, 25'h1FF_E000, 1'b0, 1'b0);
      drain();
      chk("t1_encCount", 32'(encCount), 32'd1);
      send_exp(32'h0000_07E5, 2'd1, 25'h0FC_0005, 1'b0, 1'b0);
      send_exp(32'h0000_0800, 2'd2, 25'h000_0001, 1'b0, 1'b0);
      send_exp(32'h0000_0003, 2'd3, 25'h0, 1'b0, 1'b1);
      send_exp(32'h0000_0800, 2'd0, 25'h0, 1'b1, 1'b0);
      drain();
      chk("t3_errCount", 32'(errCount), 32'd2);
      chk("t3_encCount", 32'(encCount), 32'd5);

      // Range edges of each format
      send_model(32'd2047, 2'd0);
      send_model(32'hFFFF_F800, 2'd1);
      send_model(32'hFFFF_F7FF, 2'd1);
      send_model(32'd4094, 2'd2);
      send_model(32'hFFFF_F000, 2'd2);
      send_model(32'h0000_1000, 2'd2);
      send_model(32'h000F_FFFE, 2'd3);
      send_model(32'hFFF0_0000, 2'd3);
      send_model(32'h0010_0000, 2'd3);
      drain();

      // Back-pressure: only two items fit while the output is stalled
      do_reset();
      rdy_mode = 0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         v4[k] = model(rand_imm(2'(k)), 2'(k));
      end
      idx = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         inValid = 1'b1;
         immValue = v4[idx].imm;
         immSrc = v4[idx].src;
         #1;
         if (inReady) begin
            q.push_back(v4[idx]);
            idx++;
         end
      end
      chk("t4_accepted", 32'(idx), 32'd2);
      chk("t4_inReady_low", 32'(inReady), 32'd0);
      rdy_mode = 1;
      c = 0;
      while (idx < 4 && c < 50) begin
         @(negedge clk);
         immValue = v4[idx].imm;
         immSrc = v4[idx].src;
         #1;
         if (inReady) begin
            q.push_back(v4[idx]);
            idx++;
         end
         c++;
      end
      @(posedge clk);
      #1 inValid = 1'b0;
      drain();
      chk("t4_encCount", 32'(encCount), 32'd4);

      // Random traffic with random back-pressure
      rdy_mode = 2;
      for (int n = 0; n < 10000; n++) begin
         logic [1:0] s;
         s = 2'($urandom_range(0, 3));
         send_model(rand_imm(s), s);
      end
      rdy_mode = 1;
      drain();

      // Reset with two items in flight
      rdy_mode = 0;
      @(negedge clk);
      send_model(32'd5, 2'd0);
      send_model(32'd8, 2'd2);
      @(negedge clk);
      #1 chk("t6_full_before_reset", 32'(outValid), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      q.delete();
      @(posedge clk);
      #1;
      chk("t6_outValid", 32'(outValid), 32'd0);
      chk("t6_counts", {encCount, 8'd0, errCount}, 32'd0);
      chk("t6_inReady", 32'(inReady), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      rdy_mode = 1;
      repeat (4) @(negedge clk);
      #1 chk("t6_no_stale_output", 32'(outValid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end
endmodule
